// File: rtl/pipe_pkg.sv
// Shared definitions for the generic CPU pipeline stage register.
// State encodings double as the occupancy value driven to the outside.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stageSt_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying an opaque payload.
// The producer side uses master, the consumer side uses slave.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready handshake, optional skid
// entry, flush with bubble insertion and a flush-event counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter bit                SKID_EN     = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int                CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pipe_stage_skid_if.slave  inBus,
    pipe_stage_skid_if.master outBus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] flush_cnt
);

    stageSt_e          state;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic              inReady;
    logic              inFire;
    logic              outFire;

    assign inFire       = inBus.valid & inReady;
    assign outFire      = outValid & outBus.ready;
    assign inBus.ready  = inReady;
    assign outBus.valid = outValid;
    assign outBus.data  = outData;
    assign occupancy    = state;

    if (SKID_EN) begin : gSkid
        logic [DATA_W-1:0] skidData;
        logic              readyQ;

        assign inReady = readyQ;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_EMPTY;
                outValid <= 1'b0;
                outData  <= BUBBLE_DATA;
                skidData <= '0;
                readyQ   <= 1'b1;
            end else if (flush) begin
                state    <= ST_EMPTY;
                outValid <= 1'b0;
                outData  <= BUBBLE_DATA;
                readyQ   <= 1'b1;
            end else begin
                unique case (state)
                    ST_EMPTY: begin
                        if (inFire) begin
                            state    <= ST_ONE;
                            outValid <= 1'b1;
                            outData  <= inBus.data;
                        end
                    end
                    ST_ONE: begin
                        if (inFire && !outFire) begin
                            state    <= ST_TWO;
                            skidData <= inBus.data;
                            readyQ   <= 1'b0;
                        end else if (!inFire && outFire) begin
                            state    <= ST_EMPTY;
                            outValid <= 1'b0;
                            outData  <= BUBBLE_DATA;
                        end else if (inFire && outFire) begin
                            outData  <= inBus.data;
                        end
                    end
                    ST_TWO: begin
                        // in_ready is low here, so only the drain can happen
                        if (outFire) begin
                            state    <= ST_ONE;
                            outData  <= skidData;
                            readyQ   <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_EMPTY;
                        outValid <= 1'b0;
                        outData  <= BUBBLE_DATA;
                        readyQ   <= 1'b1;
                    end
                endcase
            end
        end
    end else begin : gNoSkid
        assign inReady = !outValid | outBus.ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_EMPTY;
                outValid <= 1'b0;
                outData  <= BUBBLE_DATA;
            end else if (flush) begin
                state    <= ST_EMPTY;
                outValid <= 1'b0;
                outData  <= BUBBLE_DATA;
            end else if (inFire) begin
                state    <= ST_ONE;
                outValid <= 1'b1;
                outData  <= inBus.data;
            end else if (outFire) begin
                state    <= ST_EMPTY;
                outValid <= 1'b0;
                outData  <= BUBBLE_DATA;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) uFlushCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush & ((state != ST_EMPTY) | inFire)),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (A) and a no-skid, 2-bit
// counter instance (B), each checked every cycle against a queue model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        fl   [2];
    logic        iv   [2];
    logic        ordy [2];
    logic [31:0] id   [2];

    logic [1:0]  occA;
    logic [1:0]  occB;
    logic [15:0] cntA;
    logic [1:0]  cntB;

    int nPass  = 0;
    int nTotal = 0;

    pipe_stage_skid_if #(.DATA_W(32)) aIn  ();
    pipe_stage_skid_if #(.DATA_W(32)) aOut ();
    pipe_stage_skid_if #(.DATA_W(32)) bIn  ();
    pipe_stage_skid_if #(.DATA_W(32)) bOut ();

    assign aIn.valid  = iv[0];
    assign aIn.data   = id[0];
    assign aOut.ready = ordy[0];
    assign bIn.valid  = iv[1];
    assign bIn.data   = id[1];
    assign bOut.ready = ordy[1];

    pipe_stage_skid #(
        .DATA_W(32), .SKID_EN(1'b1), .BUBBLE_DATA(NOP), .CNT_W(16)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]),
        .inBus(aIn), .outBus(aOut),
        .occupancy(occA), .flush_cnt(cntA)
    );

    pipe_stage_skid #(
        .DATA_W(32), .SKID_EN(1'b0), .BUBBLE_DATA(NOP), .CNT_W(2)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]),
        .inBus(bIn), .outBus(bOut),
        .occupancy(occB), .flush_cnt(cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    endtask

    // Model: FIFO of accepted beats; head is what the stage presents.
    logic [31:0] mbuf [2][256];
    int          rdp  [2];
    int          wrp  [2];
    int          mcnt [2];

    function automatic int msz(input int d);
        return wrp[d] - rdp[d];
    endfunction

    function automatic bit expRdy(input int d);
        if (d == 0) return msz(0) < 2;
        return (msz(1) == 0) || ordy[1];
    endfunction

    function automatic logic [31:0] expData(input int d);
        if (msz(d) == 0) return NOP;
        return mbuf[d][rdp[d] & 255];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                rdp[d]  = 0;
                wrp[d]  = 0;
                mcnt[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                automatic int sz  = msz(d);
                automatic bit inF = iv[d] && expRdy(d);
                automatic bit otF = (sz > 0) && ordy[d];
                automatic int cmx = (d == 0) ? 65535 : 3;
                if (fl[d]) begin
                    if ((sz != 0 || inF) && mcnt[d] < cmx) mcnt[d]++;
                    rdp[d] = wrp[d];
                end else begin
                    if (otF) rdp[d]++;
                    if (inF) begin
                        mbuf[d][wrp[d] & 255] = id[d];
                        wrp[d]++;
                    end
                end
            end
        end
    end

    logic [31:0] seenB [$];

    always @(negedge clk) begin
        chk("A.valid", 32'(aOut.valid), 32'(msz(0) != 0));
        chk("A.data",  aOut.data, expData(0));
        chk("A.ready", 32'(aIn.ready), 32'(expRdy(0)));
        chk("A.occ",   32'(occA), 32'(msz(0)));
        chk("A.cnt",   32'(cntA), 32'(mcnt[0]));
        chk("B.valid", 32'(bOut.valid), 32'(msz(1) != 0));
        chk("B.data",  bOut.data, expData(1));
        chk("B.ready", 32'(bIn.ready), 32'(expRdy(1)));
        chk("B.occ",   32'(occB), 32'(msz(1)));
        chk("B.cnt",   32'(cntB), 32'(mcnt[1]));
        if (rst_n && bOut.valid && ordy[1]) seenB.push_back(bOut.data);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] x,
                         input logic r, input logic f);
        iv[d]   = v;
        id[d]   = x;
        ordy[d] = r;
        fl[d]   = f;
    endtask

    initial begin
        logic [31:0] beats [4];
        int          sent;
        beats = '{32'hA, 32'hB, 32'hC, 32'hD};
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst.A.valid", 32'(aOut.valid), 32'h0);
        chk("rst.A.data",  aOut.data, 32'h13);
        chk("rst.A.ready", 32'(aIn.ready), 32'h1);
        chk("rst.B.cnt",   32'(cntB), 32'h0);

        // 1: streaming through A, one cycle lag
        drive(0, 1'b1, 32'hA, 1'b1, 1'b0); cyc();
        chk("t1.first", aOut.data, 32'hA);
        drive(0, 1'b1, 32'hB, 1'b1, 1'b0); cyc();
        chk("t1.second", aOut.data, 32'hB);
        chk("t1.occ", 32'(occA), 32'h1);
        drive(0, 1'b1, 32'hC, 1'b1, 1'b0); cyc();
        chk("t1.third", aOut.data, 32'hC);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0); cyc();
        chk("t1.drained", 32'(aOut.valid), 32'h0);

        // 2: stall fills the skid entry, then drains in order
        drive(0, 1'b1, 32'h1, 1'b0, 1'b0); cyc();
        drive(0, 1'b1, 32'h2, 1'b0, 1'b0); cyc();
        chk("t2.occ2", 32'(occA), 32'h2);
        chk("t2.rdy0", 32'(aIn.ready), 32'h0);
        drive(0, 1'b1, 32'h3, 1'b0, 1'b0); cyc();
        chk("t2.hold", aOut.data, 32'h1);
        drive(0, 1'b1, 32'h3, 1'b1, 1'b0); cyc();
        chk("t2.out2", aOut.data, 32'h2);
        cyc();
        chk("t2.out3", aOut.data, 32'h3);
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0); cyc();

        // 3/4: flush from full, from empty idle, from empty with a beat
        drive(0, 1'b1, 32'h11, 1'b0, 1'b0); cyc();
        drive(0, 1'b1, 32'h12, 1'b0, 1'b0); cyc();
        drive(0, 1'b1, 32'h13, 1'b0, 1'b1); cyc();
        chk("t3.valid", 32'(aOut.valid), 32'h0);
        chk("t3.data",  aOut.data, 32'h13);
        chk("t3.occ",   32'(occA), 32'h0);
        chk("t3.ready", 32'(aIn.ready), 32'h1);
        chk("t3.cnt",   32'(cntA), 32'h1);
        drive(0, 1'b0, 32'h0, 1'b0, 1'b1); cyc();
        chk("t4.cnt", 32'(cntA), 32'h1);
        chk("t4.occ", 32'(occA), 32'h0);
        drive(0, 1'b1, 32'h77, 1'b0, 1'b1); cyc();
        chk("t4.inFireCnt", 32'(cntA), 32'h2);
        chk("t4.inFireOcc", 32'(occA), 32'h0);

        // 6a: asynchronous reset while two beats are held
        drive(0, 1'b1, 32'h21, 1'b0, 1'b0); cyc();
        drive(0, 1'b1, 32'h22, 1'b0, 1'b0); cyc();
        chk("t6.preOcc", 32'(occA), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.valid", 32'(aOut.valid), 32'h0);
        chk("t6.data",  aOut.data, 32'h13);
        chk("t6.ready", 32'(aIn.ready), 32'h1);
        chk("t6.occ",   32'(occA), 32'h0);
        chk("t6.cnt",   32'(cntA), 32'h0);
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // 6b: no-skid stage with out_ready toggling loses nothing
        sent = 0;
        for (int c = 0; c < 40 && sent < 4; c++) begin
            automatic bit fire;
            drive(1, 1'b1, beats[sent], c[0], 1'b0);
            fire = expRdy(1);
            cyc();
            if (fire) sent++;
        end
        chk("t6b.allSent", 32'(sent), 32'h4);
        drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        cyc();
        chk("t6b.count", 32'(seenB.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            automatic logic [31:0] got = (i < seenB.size()) ? seenB[i] : 32'hx;
            chk("t6b.beat", got, beats[i]);
        end

        // 5: 2-bit counter saturates after three discarding flushes
        drive(1, 1'b1, 32'h55, 1'b0, 1'b1); cyc();
        chk("t5.cnt1", 32'(cntB), 32'h1);
        cyc();
        cyc();
        chk("t5.cnt3", 32'(cntB), 32'h3);
        cyc();
        cyc();
        chk("t5.sat", 32'(cntB), 32'h3);
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0); cyc();

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
